// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master among NREQ requesters.
// Define SPI_ARB_FIXED_PRIO_EN to replace round robin with fixed priority (lowest index wins).
module spi_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_len,
  input  logic [4*NREQ-1:0] req_period,
  input  logic [32*NREQ-1:0] req_odata,
  input  logic              cfg_loop,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              spi_start,
  output logic [3:0]        spi_len,
  output logic [3:0]        spi_period,
  output logic [31:0]       spi_odata,
  output logic              spi_loop,
  input  logic              spi_end,
  input  logic [31:0]       spi_idata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] RUN_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   cnt;
  logic [IW-1:0] win;
  logic          grant;
  logic          launch;
  logic          fin_ok;
  logic          fin_to;

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
  end
`else
  logic [IW-1:0] ptr;
  logic          hi_found;
  logic          lo_found;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Nearest requester above ptr wins; otherwise wrap to the lowest one at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !hi_found && (IW'(i) > ptr)) begin
        hi_found = 1'b1;
        hi_idx   = IW'(i);
      end
      if (req[i] && !lo_found && (IW'(i) <= ptr)) begin
        lo_found = 1'b1;
        lo_idx   = IW'(i);
      end
    end
    win = hi_found ? hi_idx : lo_idx;
  end
`endif

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    launch    = 1'b0;
    fin_ok    = 1'b0;
    fin_to    = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        launch    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        // spi_end takes precedence over a timeout on the same cycle
        if (spi_end) begin
          fin_ok    = 1'b1;
          state_nxt = S_GAP;
        end else if (cnt == RUN_LAST) begin
          fin_to    = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One counter serves as the RUN timeout and the GAP length; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      spi_start  <= 1'b0;
      spi_len    <= '0;
      spi_period <= '0;
      spi_odata  <= '0;
      spi_loop   <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      ptr        <= IW'(NREQ - 1);
`endif
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= '0;
      err   <= 1'b0;
      case (state)
        S_RUN, S_GAP: cnt <= cnt + 32'd1;
        default:      cnt <= '0;
      endcase
      if (grant) begin
        gnt        <= {{(NREQ-1){1'b0}}, 1'b1} << win;
        spi_len    <= req_len[{win, 2'b00} +: 4];
        spi_period <= req_period[{win, 2'b00} +: 4];
        spi_odata  <= req_odata[{win, 5'b00000} +: 32];
        spi_loop   <= cfg_loop;
`ifndef SPI_ARB_FIXED_PRIO_EN
        ptr        <= win;
`endif
      end
      if (launch) spi_start <= 1'b1;
      if (fin_ok || fin_to) begin
        done      <= gnt;
        err       <= fin_to;
        gnt       <= '0;
        spi_start <= 1'b0;
        cnt       <= '0;
        if (fin_ok) rdata <= spi_idata;
      end
      if ((state == S_GAP) && (state_nxt == S_IDLE)) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized bench for spi_master_arbiter against a transaction-level arbitration model.
// Honours SPI_ARB_FIXED_PRIO_EN in the model's winner selection.
module tb_spi_master_arbiter;

  localparam int NREQ    = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 20;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_len;
  logic [4*NREQ-1:0] req_period;
  logic [32*NREQ-1:0] req_odata;
  logic              cfg_loop;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [31:0]       rdata;
  logic              busy;
  logic              spi_start;
  logic [3:0]        spi_len;
  logic [3:0]        spi_period;
  logic [31:0]       spi_odata;
  logic              spi_loop;
  logic              spi_end;
  logic [31:0]       spi_idata;

  int checks = 0;
  int errors = 0;

  logic [3:0]  lenA  [NREQ];
  logic [3:0]  perA  [NREQ];
  logic [31:0] odA   [NREQ];
  int          mPtr  = NREQ - 1;
  logic [31:0] mRdata = '0;

  spi_master_arbiter #(.NREQ(NREQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_period(req_period),
    .req_odata(req_odata), .cfg_loop(cfg_loop), .gnt(gnt), .done(done), .err(err),
    .rdata(rdata), .busy(busy), .spi_start(spi_start), .spi_len(spi_len),
    .spi_period(spi_period), .spi_odata(spi_odata), .spi_loop(spi_loop),
    .spi_end(spi_end), .spi_idata(spi_idata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Winner per the arbitration rule, searched upward from the last winner.
  function automatic int modelPick(input logic [NREQ-1:0] r);
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic randomizeDesc();
    for (int i = 0; i < NREQ; i++) begin
      lenA[i] = 4'($urandom);
      perA[i] = 4'($urandom);
      odA[i]  = $urandom;
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    req = r;
    for (int i = 0; i < NREQ; i++) begin
      req_len[4*i +: 4]     = lenA[i];
      req_period[4*i +: 4]  = perA[i];
      req_odata[32*i +: 32] = odA[i];
    end
  endtask

  // mode 0: spi_end after lat RUN cycles; 1: never (timeout); 2: spi_end on the timeout cycle.
  task automatic runOne(input logic [NREQ-1:0] r, input int mode, input int lat, input logic [31:0] idata);
    int          expW;
    int          waitN;
    int          runN;
    int          stopAt;
    int          expRun;
    logic [3:0]  eLen;
    logic [3:0]  ePer;
    logic [31:0] eOd;
    logic        eLoop;
    applyStimulus(r);
    expW  = modelPick(r);
    eLen  = lenA[expW];
    ePer  = perA[expW];
    eOd   = odA[expW];
    eLoop = cfg_loop;
    @(negedge clk);
    waitN = 1;
    while (gnt == '0 && waitN < 50) begin
      @(negedge clk);
      waitN++;
    end
    checkOutput("grant_latency", waitN, 1);
    checkOutput("gnt", gnt, 32'(1 << expW));
    checkOutput("busy_load", busy, 1);
    checkOutput("start_load", spi_start, 0);
    checkOutput("spi_len", spi_len, eLen);
    checkOutput("spi_period", spi_period, ePer);
    checkOutput("spi_odata", spi_odata, eOd);
    checkOutput("spi_loop", spi_loop, eLoop);
    mPtr = expW;
    randomizeDesc();
    applyStimulus(NREQ'($urandom));
    cfg_loop = 1'($urandom);
    @(negedge clk);
    checkOutput("start_run", spi_start, 1);
    checkOutput("gnt_run", gnt, 32'(1 << expW));
    stopAt = (mode == 0) ? lat : TIMEOUT - 1;
    expRun = (mode == 0) ? lat + 1 : TIMEOUT;
    runN = 0;
    while (done == '0 && runN < TIMEOUT + 5) begin
      spi_end   = (mode != 1) && (runN == stopAt);
      spi_idata = spi_end ? idata : $urandom;
      @(negedge clk);
      runN++;
    end
    spi_end = 1'b0;
    if (mode != 1) mRdata = idata;
    checkOutput("done_cycle", runN, expRun);
    checkOutput("done", done, 32'(1 << expW));
    checkOutput("err", err, (mode == 1) ? 1 : 0);
    checkOutput("rdata", rdata, mRdata);
    checkOutput("gnt_gap", gnt, 0);
    checkOutput("start_gap", spi_start, 0);
    checkOutput("len_stable", spi_len, eLen);
    checkOutput("odata_stable", spi_odata, eOd);
    for (int g = 1; g <= GAP; g++) begin
      spi_end = (g == 1);
      @(negedge clk);
      checkOutput("done_pulse", done, 0);
      checkOutput("gnt_idle", gnt, 0);
      checkOutput("start_idle", spi_start, 0);
      checkOutput("busy_gap", busy, (g < GAP) ? 1 : 0);
    end
    spi_end = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("gnt_onehot", 32'($onehot0(gnt)), 1);
      checkOutput("done_onehot", 32'($onehot0(done)), 1);
    end
  end

  initial begin
    int mode;
    rst       = 1'b1;
    spi_end   = 1'b0;
    spi_idata = '0;
    cfg_loop  = 1'b0;
    randomizeDesc();
    applyStimulus('0);
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_start", spi_start, 0);
    checkOutput("rst_len", spi_len, 0);
    checkOutput("rst_period", spi_period, 0);
    checkOutput("rst_odata", spi_odata, 0);
    checkOutput("rst_loop", spi_loop, 0);
    rst = 1'b0;

    $display("[TB] single request");
    lenA[1] = 4'h7;
    perA[1] = 4'h1;
    odA[1]  = 32'hA500_0000;
    runOne(4'b0010, 0, 3, 32'h0000_005A);

    $display("[TB] timeout and coincident end");
    randomizeDesc();
    runOne(4'b0100, 1, 0, 32'hDEAD_BEEF);
    randomizeDesc();
    runOne(4'b1000, 2, 0, 32'h1234_5678);

    $display("[TB] reset during RUN");
    randomizeDesc();
    applyStimulus(4'b0100);
    @(negedge clk);
    checkOutput("rst_run_gnt", gnt, 32'(1 << modelPick(4'b0100)));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    checkOutput("midrst_start", spi_start, 0);
    checkOutput("midrst_gnt", gnt, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_rdata", rdata, 0);
    rst    = 1'b0;
    mPtr   = NREQ - 1;
    mRdata = '0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("postrst_done", done, 0);
    end

    $display("[TB] all requesters active");
    for (int n = 0; n < 5; n++) begin
      randomizeDesc();
      runOne(4'b1111, 0, int'($urandom_range(0, 8)), $urandom);
    end

    $display("[TB] requesters 0 and 3");
    for (int n = 0; n < 3; n++) begin
      randomizeDesc();
      runOne(4'b1001, 0, int'($urandom_range(0, 5)), $urandom);
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 12; n++) begin
      randomizeDesc();
      cfg_loop = 1'($urandom);
      mode = int'($urandom_range(0, 4));
      mode = (mode < 3) ? 0 : mode - 2;
      runOne(NREQ'($urandom_range(1, 15)), mode, int'($urandom_range(0, 10)), $urandom);
    end

    req = '0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
